// File: rtl/alpha_startup_sequencer.sv
// Ordered bring-up sequencer: each stage waits 2^P clocks, optionally waits for a
// trigger, then emits a one-cycle startup pulse and sets a sticky completion flag.
module alpha_startup_sequencer #(
    parameter int                          NUMBER_OF_STAGES      = 3,
    parameter int                          COUNTER_PICKOFF       = 26,
    parameter int                          SHORT_COUNTER_PICKOFF = 3,
    parameter logic [NUMBER_OF_STAGES-1:0] GATED_STAGE_MASK      = 3'b100,
    localparam int                         STAGE_W = (NUMBER_OF_STAGES > 1) ? $clog2(NUMBER_OF_STAGES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        short_delay,
    input  logic                        trigger,
    input  logic                        rearm,
    output logic [NUMBER_OF_STAGES-1:0] startup_pulse,
    output logic [NUMBER_OF_STAGES-1:0] has_occurred,
    output logic [STAGE_W-1:0]          current_stage,
    output logic                        waiting_for_trigger,
    output logic                        done
);

    typedef enum logic [1:0] {
        COUNTING     = 2'd0,
        WAIT_TRIGGER = 2'd1,
        DONE         = 2'd2
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUMBER_OF_STAGES - 1);

    state_t                   state;
    logic [COUNTER_PICKOFF:0] counter;
    logic                     expired;
    logic                     fire;

    // Pickoff follows short_delay live, so a switch mid-count takes effect at once.
    assign expired = short_delay ? counter[SHORT_COUNTER_PICKOFF] : counter[COUNTER_PICKOFF];

    always_comb begin
        fire = 1'b0;
        case (state)
            COUNTING:     fire = expired && !GATED_STAGE_MASK[current_stage];
            WAIT_TRIGGER: fire = trigger;
            default:      fire = 1'b0;
        endcase
    end

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values of state, counter and current_stage.
    always_ff @(posedge clock) begin
        startup_pulse <= '0;
        if (reset) begin
            state               <= COUNTING;
            counter             <= '0;
            current_stage       <= '0;
            has_occurred        <= '0;
            waiting_for_trigger <= 1'b0;
            done                <= 1'b0;
        end else if (rearm) begin
            // Rearm outranks a same-edge fire: no pulse, flags cleared.
            state               <= COUNTING;
            counter             <= '0;
            current_stage       <= '0;
            has_occurred        <= '0;
            waiting_for_trigger <= 1'b0;
            done                <= 1'b0;
        end else if (fire) begin
            startup_pulse[current_stage] <= 1'b1;
            has_occurred[current_stage]  <= 1'b1;
            counter                      <= '0;
            waiting_for_trigger          <= 1'b0;
            if (current_stage == LAST_STAGE) begin
                state <= DONE;
                done  <= 1'b1;
            end else begin
                state         <= COUNTING;
                current_stage <= current_stage + 1'b1;
            end
        end else begin
            case (state)
                COUNTING: begin
                    if (!expired) begin
                        counter <= counter + 1'b1;
                    end else begin
                        // Only gated stages reach here with the delay expired.
                        state               <= WAIT_TRIGGER;
                        waiting_for_trigger <= 1'b1;
                    end
                end
                WAIT_TRIGGER: waiting_for_trigger <= 1'b1;
                default:      done <= 1'b1;
            endcase
        end
    end

endmodule
